// File: rtl/mae_dot_sched.sv
// Sequencer for one MAE DSP tile in accumulate mode: streams operand pairs into
// the tile, steers the feedback select and returns BIAS + sum(A*B) per job.
module mae_dot_sched #(
    parameter int AW = 18,
    parameter int CW = 40,
    parameter int LW = 16
) (
    input  logic          CLK,
    input  logic          ARST_N,
    input  logic          START,
    input  logic [LW-1:0] LEN,
    input  logic [CW-1:0] BIAS,
    output logic          BUSY,
    input  logic          OP_VALID,
    output logic          OP_READY,
    input  logic [AW-1:0] OP_A,
    input  logic [AW-1:0] OP_B,
    output logic [AW-1:0] DSP_A,
    output logic [AW-1:0] DSP_B,
    output logic [CW-1:0] DSP_C,
    output logic          DSP_A_EN,
    output logic          DSP_B_EN,
    output logic          DSP_P_EN,
    output logic          DSP_FDBK_SEL,
    input  logic [CW-1:0] DSP_P,
    output logic          RES_VALID,
    input  logic          RES_READY,
    output logic [CW-1:0] RES
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RUN    = 3'd1;
    localparam logic [2:0] S_DRAIN1 = 3'd2;
    localparam logic [2:0] S_DRAIN2 = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]    state;
    logic [LW-1:0] rem_cnt;
    logic          first_flag;
    logic          p_issue;
    logic          p_sel;
    logic [CW-1:0] dsp_c_q;
    logic [CW-1:0] res_q;
    logic          res_valid_q;
    logic          accept;

    assign OP_READY     = (state == S_RUN);
    assign BUSY         = (state != S_IDLE);
    assign accept       = OP_VALID & OP_READY;
    assign DSP_A        = OP_A;
    assign DSP_B        = OP_B;
    assign DSP_A_EN     = accept;
    assign DSP_B_EN     = accept;
    assign DSP_P_EN     = p_issue;
    assign DSP_FDBK_SEL = p_sel;
    assign DSP_C        = dsp_c_q;
    assign RES          = res_q;
    assign RES_VALID    = res_valid_q;

    // The P update trails the A/B register load by one edge, so each accept
    // arms a one-cycle issue bit; only the first pair of a job adds C.
    always_ff @(posedge CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state       <= S_IDLE;
            rem_cnt     <= '0;
            first_flag  <= 1'b1;
            p_issue     <= 1'b0;
            p_sel       <= 1'b0;
            dsp_c_q     <= '0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
        end else begin
            p_issue <= accept;
            if (accept) begin
                p_sel      <= ~first_flag;
                first_flag <= 1'b0;
                rem_cnt    <= rem_cnt - LW'(1);
            end
            case (state)
                S_IDLE: begin
                    if (START) begin
                        rem_cnt    <= LEN;
                        dsp_c_q    <= BIAS;
                        first_flag <= 1'b1;
                        if (LEN == '0) begin
                            res_q       <= BIAS;
                            res_valid_q <= 1'b1;
                            state       <= S_DONE;
                        end else begin
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (accept && (rem_cnt == LW'(1)))
                        state <= S_DRAIN1;
                end
                S_DRAIN1: state <= S_DRAIN2;
                // P now holds the final sum after the last issue pulse.
                S_DRAIN2: begin
                    res_q       <= DSP_P;
                    res_valid_q <= 1'b1;
                    state       <= S_DONE;
                end
                S_DONE: begin
                    if (RES_READY) begin
                        res_valid_q <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
